// File: rtl/nway_cache_control_pkg.sv
// Shared types and helpers for the N-way cache controller and its PLRU tree.
package cache_pkg;

    localparam int MAX_WAYS = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        EVICT      = 2'd1,
        FETCH      = 2'd2,
        WRITE_THRU = 2'd3
    } ctl_state_e;

    typedef enum logic [1:0] {
        OM_CPU    = 2'd0,
        OM_VICTIM = 2'd1,
        OM_PASS   = 2'd2
    } out_mode_e;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [2:0] lowest_set(input logic [MAX_WAYS-1:0] vec);
        logic [2:0] idx;
        idx = '0;
        for (int i = MAX_WAYS - 1; i >= 0; i--) begin
            if (vec[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/nway_cache_control_if.sv
// Bundle of CPU, cache-array and pmem control signals around the controller.
// Handshake: a CPU request (mem_read/mem_write) is held until the cycle in
// which mem_resp is 1; that cycle completes it. A pmem strobe (pmem_read/
// pmem_write) is held until the cycle in which pmem_resp is 1; that cycle
// completes the transfer. pmem_resp is only meaningful while a strobe is up.
interface nway_cache_control_if
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = 4
);
    localparam int WAY_W = $clog2(NUM_WAYS);

    logic                mem_read;
    logic                mem_write;
    logic                mem_resp;
    logic                lockout;
    logic [NUM_WAYS-1:0] hit_vec;
    logic [NUM_WAYS-1:0] valid_vec;
    logic [NUM_WAYS-1:0] dirty_vec;
    logic [NUM_WAYS-2:0] plru_out;
    logic [NUM_WAYS-2:0] plru_in;
    logic                plru_we;
    logic [NUM_WAYS-1:0] way_we;
    logic                dirty_in;
    logic                feedback_sel;
    logic [WAY_W-1:0]    output_way;
    logic [1:0]          output_mode;
    logic                pmem_resp;
    logic                pmem_read;
    logic                pmem_write;
    ctl_state_e          state;

    modport master (
        input  mem_read, mem_write, lockout, hit_vec, valid_vec, dirty_vec,
               plru_out, pmem_resp,
        output mem_resp, plru_in, plru_we, way_we, dirty_in, feedback_sel,
               output_way, output_mode, pmem_read, pmem_write, state
    );

    modport slave (
        output mem_read, mem_write, lockout, hit_vec, valid_vec, dirty_vec,
               plru_out, pmem_resp,
        input  mem_resp, plru_in, plru_we, way_we, dirty_in, feedback_sel,
               output_way, output_mode, pmem_read, pmem_write, state
    );

endinterface

// File: rtl/nway_cache_control_plru_tree.sv
// Combinational tree pseudo-LRU: victim selection and access update.
// Heap layout: node 0 is the root, children of node i are 2i+1 (lower half)
// and 2i+2 (upper half). A bit of 1 points at the upper half.
module plru_tree
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = 4
) (
    input  logic [NUM_WAYS-2:0]         plru_out,
    input  logic [NUM_WAYS-1:0]         valid_vec,
    input  logic [$clog2(NUM_WAYS)-1:0] access_way,
    output logic [$clog2(NUM_WAYS)-1:0] victim,
    output logic [NUM_WAYS-2:0]         plru_in
);
    localparam int WAY_W = $clog2(NUM_WAYS);

    logic [WAY_W-1:0] walk;

    // Follow the tree bits from the root; at level l the node visited is the
    // one whose position matches the way bits chosen so far.
    always_comb begin
        walk = '0;
        for (int l = 0; l < WAY_W; l++) begin
            for (int p = 0; p < (1 << l); p++) begin
                if (int'(walk >> (WAY_W - l)) == p) begin
                    walk[WAY_W-1-l] = plru_out[(1 << l) - 1 + p];
                end
            end
        end
    end

    // An invalid way is always preferred over evicting a live line.
    always_comb begin
        if (!(&valid_vec)) victim = WAY_W'(lowest_set(MAX_WAYS'(~valid_vec)));
        else               victim = walk;
    end

    // Point every node on the accessed way's path away from it.
    always_comb begin
        plru_in = plru_out;
        for (int l = 0; l < WAY_W; l++) begin
            for (int p = 0; p < (1 << l); p++) begin
                if (int'(access_way >> (WAY_W - l)) == p) begin
                    plru_in[(1 << l) - 1 + p] = ~access_way[WAY_W-1-l];
                end
            end
        end
    end

endmodule

// File: rtl/nway_cache_control.sv
// Control FSM for an N-way set-associative write-back L1 cache.
module nway_cache_control
    import cache_pkg::*;
#(
    parameter int NUM_WAYS       = 4,
    parameter bit WRITE_ALLOCATE = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    nway_cache_control_if.master bus
);
    localparam int WAY_W = $clog2(NUM_WAYS);

    ctl_state_e          state_q, state_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic [WAY_W-1:0]    hit_way, victim, access_way;
    logic [NUM_WAYS-2:0] plru_upd;
    logic                req, any_hit;

    assign req      = bus.mem_read | bus.mem_write;
    assign any_hit  = |bus.hit_vec;
    assign hit_way  = WAY_W'(lowest_set(MAX_WAYS'(bus.hit_vec)));
    // The fill updates PLRU for the latched victim; a hit updates its own way.
    assign access_way = (state_q == FETCH) ? victim_q : hit_way;
    assign bus.state  = state_q;

    plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
        .plru_out   (bus.plru_out),
        .valid_vec  (bus.valid_vec),
        .access_way (access_way),
        .victim     (victim),
        .plru_in    (plru_upd)
    );

    // State and latched victim; victim_q only changes when a miss starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    // Next state and all outputs; everything is forced idle while in reset.
    always_comb begin
        state_d          = state_q;
        victim_d         = victim_q;
        bus.mem_resp     = 1'b0;
        bus.plru_we      = 1'b0;
        bus.plru_in      = '0;
        bus.way_we       = '0;
        bus.dirty_in     = 1'b0;
        bus.feedback_sel = 1'b0;
        bus.output_way   = '0;
        bus.output_mode  = OM_CPU;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                IDLE: begin
                    if (req && any_hit) begin
                        bus.mem_resp   = 1'b1;
                        bus.output_way = hit_way;
                        bus.plru_we    = 1'b1;
                        bus.plru_in    = plru_upd;
                        if (bus.mem_write) begin
                            bus.way_we[hit_way] = 1'b1;
                            bus.dirty_in        = 1'b1;
                            bus.feedback_sel    = 1'b1;
                        end
                    end else if (req && !bus.lockout) begin
                        if (!WRITE_ALLOCATE && bus.mem_write) begin
                            state_d = WRITE_THRU;
                        end else begin
                            victim_d = victim;
                            state_d  = (bus.dirty_vec[victim] && bus.valid_vec[victim])
                                       ? EVICT : FETCH;
                        end
                    end
                end
                EVICT: begin
                    bus.output_way  = victim_q;
                    bus.output_mode = OM_VICTIM;
                    bus.pmem_write  = 1'b1;
                    if (bus.pmem_resp) state_d = FETCH;
                end
                FETCH: begin
                    bus.pmem_read = 1'b1;
                    if (bus.pmem_resp) begin
                        bus.way_we[victim_q] = 1'b1;
                        bus.plru_we          = 1'b1;
                        bus.plru_in          = plru_upd;
                        state_d              = IDLE;
                    end
                end
                WRITE_THRU: begin
                    bus.output_mode = OM_PASS;
                    bus.pmem_write  = 1'b1;
                    if (bus.pmem_resp) begin
                        bus.mem_resp = 1'b1;
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Two ways claiming the same tag is a datapath bug.
    assert property (@(posedge clk) disable iff (!rst_n) req |-> $onehot0(bus.hit_vec));

endmodule

// File: tb/tb_nway_cache_control.sv
// Bench for nway_cache_control with NUM_WAYS=4: vector table, corner-case
// sequences and a randomized run against a behavioural model.
module tb_nway_cache_control;
    import cache_pkg::*;

    localparam int N    = 4;
    localparam int LOGN = 2;

    typedef struct packed {
        logic       mem_resp;
        logic       plru_we;
        logic [2:0] plru_in;
        logic [3:0] way_we;
        logic       dirty_in;
        logic       feedback_sel;
        logic [1:0] output_way;
        logic [1:0] output_mode;
        logic       pmem_read;
        logic       pmem_write;
    } outs_t;

    typedef struct {
        logic       rd, wr, lk, presp;
        logic [3:0] hit, valid, dirty;
        logic [2:0] plru;
        outs_t      exp;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    checks = 0;
    int    errors = 0;
    outs_t act_main, act_wt;
    vec_t  vecs[9];

    nway_cache_control_if #(.NUM_WAYS(N)) bus ();
    nway_cache_control_if #(.NUM_WAYS(N)) bus_wt ();

    nway_cache_control #(.NUM_WAYS(N), .WRITE_ALLOCATE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    nway_cache_control #(.NUM_WAYS(N), .WRITE_ALLOCATE(1'b0)) dut_wt (
        .clk(clk), .rst_n(rst_n), .bus(bus_wt)
    );

    always #5 clk = ~clk;

    assign act_main = {bus.mem_resp, bus.plru_we, bus.plru_in, bus.way_we, bus.dirty_in,
                       bus.feedback_sel, bus.output_way, bus.output_mode, bus.pmem_read,
                       bus.pmem_write};
    assign act_wt   = {bus_wt.mem_resp, bus_wt.plru_we, bus_wt.plru_in, bus_wt.way_we,
                       bus_wt.dirty_in, bus_wt.feedback_sel, bus_wt.output_way,
                       bus_wt.output_mode, bus_wt.pmem_read, bus_wt.pmem_write};

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic outs_t mk(logic r, logic pwe, logic [2:0] pin, logic [3:0] wwe,
                                 logic din, logic fb, logic [1:0] ow, logic [1:0] om,
                                 logic pr, logic pw);
        outs_t o;
        o.mem_resp = r;   o.plru_we = pwe;  o.plru_in = pin;    o.way_we = wwe;
        o.dirty_in = din; o.feedback_sel = fb; o.output_way = ow; o.output_mode = om;
        o.pmem_read = pr; o.pmem_write = pw;
        return o;
    endfunction

    // Reference model: lowest invalid way, else descend the heap by the bits.
    function automatic int ref_victim(logic [3:0] valid, logic [2:0] plru);
        int node, way, b;
        for (int w = 0; w < N; w++) if (!valid[w]) return w;
        node = 0; way = 0;
        for (int l = 0; l < LOGN; l++) begin
            b    = int'(plru[node]);
            way  = way * 2 + b;
            node = 2 * node + 1 + b;
        end
        return way;
    endfunction

    function automatic logic [2:0] ref_update(logic [2:0] plru, int w);
        logic [2:0] r;
        int node, b;
        r = plru; node = 0;
        for (int l = LOGN - 1; l >= 0; l--) begin
            b       = (w >> l) & 1;
            r[node] = (b == 0);
            node    = 2 * node + 1 + b;
        end
        return r;
    endfunction

    task automatic chk_outs(string name, outs_t act, outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_val(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(logic rd, logic wr, logic lk, logic [3:0] hit, logic [3:0] valid,
                         logic [3:0] dirty, logic [2:0] plru, logic presp);
        bus.mem_read = rd;  bus.mem_write = wr; bus.lockout = lk; bus.hit_vec = hit;
        bus.valid_vec = valid; bus.dirty_vec = dirty; bus.plru_out = plru;
        bus.pmem_resp = presp;
    endtask

    task automatic drive_wt(logic rd, logic wr, logic presp);
        bus_wt.mem_read = rd; bus_wt.mem_write = wr; bus_wt.lockout = 1'b0;
        bus_wt.hit_vec = 4'b0000; bus_wt.valid_vec = 4'b0000; bus_wt.dirty_vec = 4'b0000;
        bus_wt.plru_out = 3'b000; bus_wt.pmem_resp = presp;
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    outs_t zero, ev_out, fe_out;

    initial begin
        zero   = '0;
        ev_out = mk(0, 0, 3'b000, 4'b0000, 0, 0, 2'd0, 2'd1, 0, 1);
        fe_out = mk(0, 0, 3'b000, 4'b0000, 0, 0, 2'd0, 2'd0, 1, 0);

        vecs[0] = '{0, 0, 0, 0, 4'b0000, 4'b1111, 4'b0000, 3'b000, zero};
        vecs[1] = '{1, 0, 0, 0, 4'b0001, 4'b1111, 4'b0000, 3'b000,
                    mk(1, 1, 3'b011, 4'b0000, 0, 0, 2'd0, 2'd0, 0, 0)};
        vecs[2] = '{1, 0, 0, 0, 4'b1000, 4'b1111, 4'b0000, 3'b000,
                    mk(1, 1, 3'b000, 4'b0000, 0, 0, 2'd3, 2'd0, 0, 0)};
        vecs[3] = '{0, 1, 0, 0, 4'b0100, 4'b1111, 4'b0000, 3'b000,
                    mk(1, 1, 3'b100, 4'b0100, 1, 1, 2'd2, 2'd0, 0, 0)};
        vecs[4] = '{0, 1, 0, 0, 4'b0010, 4'b1111, 4'b1111, 3'b111,
                    mk(1, 1, 3'b101, 4'b0010, 1, 1, 2'd1, 2'd0, 0, 0)};
        vecs[5] = '{1, 0, 1, 0, 4'b0000, 4'b1111, 4'b1111, 3'b000, zero};
        vecs[6] = '{0, 1, 1, 0, 4'b1000, 4'b1111, 4'b0000, 3'b010,
                    mk(1, 1, 3'b010, 4'b1000, 1, 1, 2'd3, 2'd0, 0, 0)};
        vecs[7] = '{0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 3'b000, zero};
        vecs[8] = '{1, 0, 0, 0, 4'b0010, 4'b0011, 4'b0011, 3'b000,
                    mk(1, 1, 3'b001, 4'b0000, 0, 0, 2'd1, 2'd0, 0, 0)};

        // Reset: a read hit is presented but nothing may respond.
        drive(1, 0, 0, 4'b0001, 4'b1111, 4'b0000, 3'b000, 1);
        drive_wt(0, 1, 1);
        cycle(); cycle(); #2;
        chk_outs("reset_outs", act_main, zero);
        chk_val("reset_state", int'(bus.state), int'(IDLE));
        chk_outs("reset_outs_wt", act_wt, zero);
        cycle();
        drive(0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 3'b000, 0);
        drive_wt(0, 0, 0);
        rst_n = 1'b1;

        // Single-cycle IDLE behaviour from the vector table.
        for (int i = 0; i < 9; i++) begin
            cycle();
            drive(vecs[i].rd, vecs[i].wr, vecs[i].lk, vecs[i].hit, vecs[i].valid,
                  vecs[i].dirty, vecs[i].plru, vecs[i].presp);
            #2 chk_outs($sformatf("vec%0d", i), act_main, vecs[i].exp);
            @(posedge clk); #1;
            chk_val($sformatf("vec%0d_state", i), int'(bus.state), int'(IDLE));
        end

        // Clean read miss into empty set: fill way 0, then hit.
        cycle(); drive(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 3'b000, 0);
        #2 chk_outs("clean_idle", act_main, zero);
        cycle(); #2;
        chk_val("clean_state", int'(bus.state), int'(FETCH));
        chk_outs("clean_fetch", act_main, fe_out);
        cycle(); bus.pmem_resp = 1; #2;
        chk_outs("clean_fill", act_main, mk(0, 1, 3'b011, 4'b0001, 0, 0, 2'd0, 2'd0, 1, 0));
        cycle(); drive(1, 0, 0, 4'b0001, 4'b0001, 4'b0000, 3'b011, 0); #2;
        chk_outs("clean_hit", act_main, mk(1, 1, 3'b011, 4'b0000, 0, 0, 2'd0, 2'd0, 0, 0));
        cycle(); drive(0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 3'b000, 0);

        // Dirty victim: evict with three wait cycles, then fill.
        cycle(); drive(1, 0, 0, 4'b0000, 4'b1111, 4'b0001, 3'b000, 0);
        #2 chk_outs("dirty_idle", act_main, zero);
        cycle(); #2;
        chk_val("dirty_state", int'(bus.state), int'(EVICT));
        chk_outs("dirty_evict", act_main, ev_out);
        for (int i = 0; i < 3; i++) begin
            cycle(); #2 chk_outs($sformatf("dirty_wait%0d", i), act_main, ev_out);
        end
        cycle(); bus.pmem_resp = 1; #2 chk_outs("dirty_evict_ack", act_main, ev_out);
        cycle(); bus.pmem_resp = 0; #2;
        chk_val("dirty_fetch_state", int'(bus.state), int'(FETCH));
        chk_outs("dirty_fetch", act_main, fe_out);
        cycle(); bus.pmem_resp = 1; #2;
        chk_outs("dirty_fill", act_main, mk(0, 1, 3'b011, 4'b0001, 0, 0, 2'd0, 2'd0, 1, 0));
        cycle(); drive(0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 3'b000, 0);

        // PLRU victim way 3, inputs disturbed mid-fetch: latched victim wins.
        cycle(); drive(1, 0, 0, 4'b0000, 4'b1111, 4'b0000, 3'b101, 0);
        cycle(); drive(1, 0, 0, 4'b0000, 4'b0111, 4'b0000, 3'b011, 0); #2;
        chk_outs("plru_fetch", act_main, fe_out);
        cycle(); bus.pmem_resp = 1; #2;
        chk_outs("plru_fill", act_main, mk(0, 1, 3'b010, 4'b1000, 0, 0, 2'd0, 2'd0, 1, 0));
        cycle(); drive(0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 3'b000, 0);

        // Write-through on the no-allocate instance.
        cycle(); drive_wt(0, 1, 0); #2 chk_outs("wt_idle", act_wt, zero);
        cycle(); #2;
        chk_val("wt_state", int'(bus_wt.state), int'(WRITE_THRU));
        chk_outs("wt_busy", act_wt, mk(0, 0, 3'b000, 4'b0000, 0, 0, 2'd0, 2'd2, 0, 1));
        cycle(); bus_wt.pmem_resp = 1; #2;
        chk_outs("wt_ack", act_wt, mk(1, 0, 3'b000, 4'b0000, 0, 0, 2'd0, 2'd2, 0, 1));
        cycle(); drive_wt(1, 0, 0); #2;
        chk_val("wt_back_idle", int'(bus_wt.state), int'(IDLE));
        cycle(); #2 chk_val("wt_read_alloc", int'(bus_wt.state), int'(FETCH));
        cycle(); bus_wt.pmem_resp = 1;
        cycle(); drive_wt(0, 0, 0); #2 chk_val("wt_read_done", int'(bus_wt.state), int'(IDLE));

        // Reset in the middle of an eviction.
        cycle(); drive(1, 0, 0, 4'b0000, 4'b1111, 4'b1111, 3'b000, 0);
        cycle(); #2 chk_outs("rst_evict", act_main, ev_out);
        rst_n = 1'b0; #1;
        chk_val("rst_pmem_write", int'(bus.pmem_write), 0);
        chk_val("rst_mid_state", int'(bus.state), int'(IDLE));
        cycle(); drive(0, 0, 0, 4'b0000, 4'b1111, 4'b1111, 3'b000, 1);
        rst_n = 1'b1; #2;
        chk_outs("rst_stray_resp", act_main, zero);
        cycle(); #2 chk_val("rst_stray_state", int'(bus.state), int'(IDLE));
        bus.pmem_resp = 0;

        // Randomized run against the behavioural model.
        begin
            ctl_state_e ph, ph_n;
            int         mv, hw;
            logic       rd, wr, lk, rs;
            logic [3:0] hit, valid, dirty;
            logic [2:0] plru;
            outs_t      e;
            ph = IDLE; mv = 0;
            for (int c = 0; c < 500; c++) begin
                cycle();
                wr    = 1'($urandom_range(0, 1));
                rd    = !wr && ($urandom_range(0, 3) != 0);
                if (!rd && !wr && $urandom_range(0, 1) == 0) wr = 1'b1;
                hit   = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
                valid = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
                dirty = 4'($urandom_range(0, 15));
                plru  = 3'($urandom_range(0, 7));
                lk    = ($urandom_range(0, 3) == 0);
                rs    = ($urandom_range(0, 2) == 0);
                drive(rd, wr, lk, hit, valid, dirty, plru, rs);
                e = '0; ph_n = ph;
                case (ph)
                    IDLE: begin
                        if ((rd || wr) && hit != 0) begin
                            hw = 0;
                            while (!hit[hw]) hw++;
                            e.mem_resp = 1; e.plru_we = 1; e.output_way = 2'(hw);
                            e.plru_in = ref_update(plru, hw);
                            if (wr) begin
                                e.way_we = 4'(1 << hw); e.dirty_in = 1; e.feedback_sel = 1;
                            end
                        end else if ((rd || wr) && !lk) begin
                            mv   = ref_victim(valid, plru);
                            ph_n = (valid[mv] && dirty[mv]) ? EVICT : FETCH;
                        end
                    end
                    EVICT: begin
                        e.output_way = 2'(mv); e.output_mode = 2'd1; e.pmem_write = 1;
                        if (rs) ph_n = FETCH;
                    end
                    FETCH: begin
                        e.pmem_read = 1;
                        if (rs) begin
                            e.way_we = 4'(1 << mv); e.plru_we = 1;
                            e.plru_in = ref_update(plru, mv);
                            ph_n = IDLE;
                        end
                    end
                    default: ph_n = IDLE;
                endcase
                #2;
                chk_outs($sformatf("rand%0d", c), act_main, e);
                chk_val($sformatf("rand%0d_state", c), int'(bus.state), int'(ph));
                ph = ph_n;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
